// File: rtl/sdram_bist.sv
// sdram_bist: two-pass write/readback test engine driving sdram_controller.
// Define SDRAM_BIST_LOOP_EN to add auto-repeat (loop, iter_count).
module sdram_bist #(
   parameter logic [31:0] START_ADDR  = 32'd0,
   parameter logic [31:0] END_ADDR    = 32'd1023,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  mode,
`ifdef SDRAM_BIST_LOOP_EN
   input  logic        loop,
   output logic [15:0] iter_count,
`endif
   output logic [31:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        wr_enable,
   output logic [31:0] rd_addr,
   output logic        rd_enable,
   input  logic [15:0] rd_data,
   input  logic        rd_ready,
   input  logic        busy,
   output logic        active,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic        timeout_seen,
   output logic [31:0] first_err_addr,
   output logic [15:0] first_err_exp,
   output logic [15:0] first_err_got
);

   if (END_ADDR < START_ADDR) begin : g_bad_window
      $error("sdram_bist: END_ADDR < START_ADDR");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("sdram_bist: LFSR_SEED must be nonzero");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_WR_WAIT, S_WR_GUARD, S_RD_WAIT,
      S_RD_GUARD, S_RD_DATA, S_DONE
   } state_e;

   localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  mode_q, mode_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic        rd_en_q, rd_en_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic        active_q, active_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [15:0] err_q, err_d;
   logic        tmo_q, tmo_d;
   logic [31:0] fe_addr_q, fe_addr_d;
   logic [15:0] fe_exp_q, fe_exp_d;
   logic [15:0] fe_got_q, fe_got_d;
`ifdef SDRAM_BIST_LOOP_EN
   logic [15:0] iter_q, iter_d;
`endif

   logic [15:0] pat;
   logic [15:0] lfsr_nxt;
   logic        fail, proceed, restart, clear;
   logic [15:0] fail_got;

   assign lfsr_nxt = {lfsr_q[14:0],
                      lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_comb begin
      case (mode_q)
         2'd0:    pat = addr_q[15:0];
         2'd1:    pat = ~addr_q[15:0];
         2'd2:    pat = addr_q[0] ? 16'hAAAA : 16'h5555;
         default: pat = lfsr_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      lfsr_d    = lfsr_q;
      mode_d    = mode_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_en_d   = 1'b0;
      tcnt_d    = tcnt_q;
      active_d  = active_q;
      done_d    = done_q;
      pass_d    = pass_q;
      err_d     = err_q;
      tmo_d     = tmo_q;
      fe_addr_d = fe_addr_q;
      fe_exp_d  = fe_exp_q;
      fe_got_d  = fe_got_q;
`ifdef SDRAM_BIST_LOOP_EN
      iter_d    = iter_q;
`endif
      fail      = 1'b0;
      fail_got  = rd_data;
      proceed   = 1'b0;
      restart   = 1'b0;
      clear     = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               restart = 1'b1;
               clear   = 1'b1;
            end
`ifdef SDRAM_BIST_LOOP_EN
            else if (state_q == S_DONE && loop) begin
               restart = 1'b1;
            end
`endif
         end
         S_WR_WAIT: begin
            if (!busy) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = pat;
               state_d   = S_WR_GUARD;
            end
         end
         S_WR_GUARD: begin
            if (addr_q == END_ADDR) begin
               addr_d  = START_ADDR;
               lfsr_d  = LFSR_SEED;
               state_d = S_RD_WAIT;
            end else begin
               addr_d  = addr_q + 32'd1;
               lfsr_d  = lfsr_nxt;
               state_d = S_WR_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (!busy) begin
               rd_en_d   = 1'b1;
               rd_addr_d = addr_q;
               tcnt_d    = '0;
               state_d   = S_RD_GUARD;
            end
         end
         S_RD_GUARD: begin
            if (rd_ready) begin
               proceed = 1'b1;
               fail    = (rd_data != pat);
            end else begin
               tcnt_d  = tcnt_q + 16'd1;
               state_d = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (rd_ready) begin
               proceed = 1'b1;
               fail    = (rd_data != pat);
            end else if (tcnt_q >= TMO) begin
               proceed  = 1'b1;
               fail     = 1'b1;
               fail_got = 16'h0000;
               tmo_d    = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // err_q==0 marks the first failure; saturation never returns it to 0
      if (fail) begin
         if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
         if (err_q == 16'h0000) begin
            fe_addr_d = addr_q;
            fe_exp_d  = pat;
            fe_got_d  = fail_got;
         end
      end

      if (proceed) begin
         if (addr_q == END_ADDR) begin
            state_d  = S_DONE;
            active_d = 1'b0;
            done_d   = 1'b1;
            pass_d   = (err_d == 16'h0000);
`ifdef SDRAM_BIST_LOOP_EN
            iter_d   = iter_q + 16'd1;
`endif
         end else begin
            addr_d  = addr_q + 32'd1;
            lfsr_d  = lfsr_nxt;
            state_d = S_RD_WAIT;
         end
      end

      if (restart) begin
         if (clear) mode_d = mode;
         addr_d   = START_ADDR;
         lfsr_d   = LFSR_SEED;
         done_d   = 1'b0;
         pass_d   = 1'b0;
         active_d = 1'b1;
         state_d  = S_WR_WAIT;
      end

      if (clear) begin
         err_d     = '0;
         tmo_d     = 1'b0;
         fe_addr_d = '0;
         fe_exp_d  = '0;
         fe_got_d  = '0;
`ifdef SDRAM_BIST_LOOP_EN
         iter_d    = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         lfsr_q    <= LFSR_SEED;
         mode_q    <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         tcnt_q    <= '0;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= '0;
         tmo_q     <= 1'b0;
         fe_addr_q <= '0;
         fe_exp_q  <= '0;
         fe_got_q  <= '0;
`ifdef SDRAM_BIST_LOOP_EN
         iter_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         lfsr_q    <= lfsr_d;
         mode_q    <= mode_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
         tcnt_q    <= tcnt_d;
         active_q  <= active_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         fe_addr_q <= fe_addr_d;
         fe_exp_q  <= fe_exp_d;
         fe_got_q  <= fe_got_d;
`ifdef SDRAM_BIST_LOOP_EN
         iter_q    <= iter_d;
`endif
      end
   end

   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign wr_enable      = wr_en_q;
   assign rd_addr        = rd_addr_q;
   assign rd_enable      = rd_en_q;
   assign active         = active_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign timeout_seen   = tmo_q;
   assign first_err_addr = fe_addr_q;
   assign first_err_exp  = fe_exp_q;
   assign first_err_got  = fe_got_q;
`ifdef SDRAM_BIST_LOOP_EN
   assign iter_count     = iter_q;
`endif

endmodule

// File: tb/tb_sdram_bist.sv
// tb_sdram_bist: randomized controller model plus pattern/error reference.
// Loop checks compile in when SDRAM_BIST_LOOP_EN is defined.
module tb_sdram_bist;

   localparam logic [31:0] SA = 32'd16;
   localparam logic [31:0] EA = 32'd47;
   localparam int N = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] rd_data = 16'h0;
   logic        rd_ready = 1'b0;
   logic        busy = 1'b0;
   logic [31:0] wr_addr, rd_addr, first_err_addr;
   logic [15:0] wr_data, err_count, first_err_exp, first_err_got;
   logic        wr_enable, rd_enable, active, done, pass, timeout_seen;
`ifdef SDRAM_BIST_LOOP_EN
   logic        loop = 1'b0;
   logic [15:0] iter_count;
`endif

   sdram_bist #(.START_ADDR(SA), .END_ADDR(EA)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
`ifdef SDRAM_BIST_LOOP_EN
      .loop(loop), .iter_count(iter_count),
`endif
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
      .rd_addr(rd_addr), .rd_enable(rd_enable),
      .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy),
      .active(active), .done(done), .pass(pass),
      .err_count(err_count), .timeout_seen(timeout_seen),
      .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
      .first_err_got(first_err_got)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int          cfg_mode;
   logic [N-1:0] cor_mask, wh_mask;
   bit          cor_zero, force_busy;
   int          wi, ri, exp_err;
   bit          exp_tmo;
   logic [31:0] fe_a;
   logic [15:0] fe_e, fe_g;
   logic [15:0] mem [N];
   int          mb_cnt, lat, pidx;
   bit          pend;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference pattern for the idx-th word of the window
   function automatic logic [15:0] pat(int m, int idx);
      logic [31:0] a;
      logic [15:0] l;
      a = SA + idx;
      l = 16'hACE1;
      for (int k = 0; k < idx; k++) l = {l[14:0], ^(l & 16'hB400)};
      case (m)
         0:       return a[15:0];
         1:       return ~a[15:0];
         2:       return a[0] ? 16'hAAAA : 16'h5555;
         default: return l;
      endcase
   endfunction

   task automatic note_err(int idx, logic [15:0] got, bit tmo);
      if (exp_err == 0) begin
         fe_a = SA + idx;
         fe_e = pat(cfg_mode, idx);
         fe_g = got;
      end
      exp_err++;
      if (tmo) exp_tmo = 1'b1;
   endtask

   // Controller model: acts on the falling edge, away from DUT sampling
   initial begin
      logic [15:0] d;
      int idx;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend = 0; mb_cnt = 0; rd_ready = 1'b0;
            busy = force_busy;
         end else begin
            rd_ready = 1'b0;
            if (mb_cnt > 0) mb_cnt--;
            if (wr_enable) begin
               idx = wi % N;
               chk("wr_nobusy", busy, 0);
               chk("wr_addr", wr_addr, SA + idx);
               chk("wr_data", wr_data, pat(cfg_mode, idx));
               mem[idx] = wr_data;
               wi++;
               mb_cnt = $urandom_range(0, 3);
            end
            if (rd_enable) begin
               idx = ri % N;
               chk("rd_nobusy", busy, 0);
               chk("rd_addr", rd_addr, SA + idx);
               ri++;
               if (wh_mask[idx]) note_err(idx, 16'h0, 1);
               else begin
                  pend = 1; pidx = idx; lat = $urandom_range(0, 4);
               end
            end
            if (pend) begin
               if (lat == 0) begin
                  d = mem[pidx];
                  if (cor_mask[pidx]) d = cor_zero ? 16'h0 : ~d;
                  rd_data = d;
                  rd_ready = 1'b1;
                  if (d != pat(cfg_mode, pidx)) note_err(pidx, d, 0);
                  pend = 0;
               end else lat--;
            end
            busy = force_busy || (mb_cnt > 0) || pend;
         end
      end
   end

   task automatic clr_model(int m, logic [N-1:0] cm, bit cz,
                            logic [N-1:0] wm);
      cfg_mode = m; cor_mask = cm; cor_zero = cz; wh_mask = wm;
      wi = 0; ri = 0; exp_err = 0; exp_tmo = 0;
      fe_a = '0; fe_e = '0; fe_g = '0;
   endtask

   task automatic pulse_start(int m);
      @(negedge clk);
      mode = 2'(m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 2'($urandom);
      chk("active_on", active, 1);
      chk("done_clr", done, 0);
   endtask

   task automatic chk_result(int iters);
      chk("wr_count", wi, iters * N);
      chk("rd_count", ri, iters * N);
      chk("active_off", active, 0);
      chk("err_count", err_count, exp_err);
      chk("pass", pass, exp_err == 0);
      chk("timeout_seen", timeout_seen, exp_tmo);
      chk("fe_addr", first_err_addr, fe_a);
      chk("fe_exp", first_err_exp, fe_e);
      chk("fe_got", first_err_got, fe_g);
   endtask

   task automatic run(int m, logic [N-1:0] cm, bit cz, logic [N-1:0] wm,
                      bit hold, bit rst_mid);
      int wb;
      int k;
      clr_model(m, cm, cz, wm);
      pulse_start(m);
      if (hold) begin
         for (k = 0; k < 2000 && wi < 10; k++) @(negedge clk);
         force_busy = 1; busy = 1'b1;
         @(negedge clk);
         wb = wi;
         repeat (199) @(negedge clk);
         chk("hold_no_wr", wi, wb);
         force_busy = 0;
      end
      if (rst_mid) begin
         for (k = 0; k < 3000 && ri < 10; k++) @(negedge clk);
         chk("rd_pass_reached", ri >= 10, 1);
         rst_n = 1'b0;
         #1;
         chk("rst_ctl", {wr_enable, rd_enable, active, done, pass,
                         timeout_seen, err_count}, 0);
         chk("rst_addr", {wr_addr, rd_addr}, 0);
         chk("rst_dat", {wr_data, first_err_exp, first_err_got}, 0);
         chk("rst_fea", first_err_addr, 0);
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
      end else begin
         for (k = 0; k < 5000 && !done; k++) @(negedge clk);
         chk("done_seen", done, 1);
         chk_result(1);
      end
   endtask

   initial begin
      logic [N-1:0] m1;
      force_busy = 0;
      clr_model(0, '0, 0, '0);
      #2;
      chk("rst0_ctl", {wr_enable, rd_enable, active, done, pass,
                       timeout_seen, err_count}, 0);
      chk("rst0_fe", {first_err_addr, first_err_got}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run(0, '0, 0, '0, 0, 0);
      run(2, N'(1) << 5, 1, '0, 0, 0);
      chk("corrupt_exp_model", fe_e, 16'hAAAA);
      run(1, '0, 0, '0, 1, 0);
      run(int'($urandom_range(0, 3)), '0, 0, N'(1) << 3, 0, 0);
      run(3, '0, 0, '0, 0, 1);
      run(3, '0, 0, '0, 0, 0);
      for (int t = 0; t < 3; t++) begin
         m1 = N'($urandom & $urandom & $urandom);
         run(int'($urandom_range(0, 3)), m1, t[0], N'(1) << $urandom_range(0, N - 1), 0, 0);
      end

`ifdef SDRAM_BIST_LOOP_EN
      begin
         int pulses;
         int k;
         pulses = 0;
         clr_model(int'($urandom_range(0, 3)), N'($urandom & $urandom), 0, '0);
         loop = 1'b1;
         pulse_start(cfg_mode);
         for (k = 0; k < 20000 && pulses < 3; k++) begin
            @(negedge clk);
            if (done) pulses++;
            else if (pulses == 2) loop = 1'b0;
         end
         chk("loop_pulses", pulses, 3);
         repeat (3) @(negedge clk);
         chk("loop_iter", iter_count, 3);
         chk("loop_done_hold", done, 1);
         chk_result(3);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
